fetch_predict_unit: RTL and testbench
=====================================

FETCH_PREDICT_UNIT -- requirements
Module: fetch_predict_unit

Interface
REQ-001 SHALL provide parameter BHT_BITS, default 6, meaning log2 of branch-history-table entries (64).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 SHALL provide ports, one per line:
  Clk  in  1  single clock, all state on rising edge.
  Reset  in  1  asynchronous, active-low reset (asserted when 0).
  Fetch_Enable  in  1  1 = PC advances; 0 = hold PC (stall).
  InstructionIn  in  32  instruction-memory read data for address PCF (combinational memory).
  ResolveValid  in  1  EX stage resolved a conditional branch this cycle.
  ResolvePC  in  32  address of the resolved branch.
  ResolveTaken  in  1  actual branch outcome.
  Mispredict  in  1  redirect required this cycle.
  CorrectPC  in  32  redirect target.
  PCF  out  32  current fetch address to instruction memory.
  PCPlus4F  out  32  PCF + 4.
  InstructionF  out  32  equals InstructionIn.
  predictF  out  1  1 = this instruction predicted taken (branch or jump).

Function
REQ-004 PCF SHALL be a register; PCPlus4F, InstructionF and predictF SHALL be combinational from PCF, InstructionIn and the BHT.
REQ-005 Predecode SHALL classify InstructionIn[31:26]: 000100 (beq) and 000101 (bne) = conditional branch; 000010 (j) = jump; all else = sequential.
REQ-006 BHT SHALL hold 2^BHT_BITS 2-bit saturating counters indexed by PCF[BHT_BITS+1:2]; lookup for updates indexed by ResolvePC[BHT_BITS+1:2].
REQ-007 Conditional branch predictF SHALL be counter[1] (counter value 2 or 3 = taken); jump predictF SHALL be 1; sequential predictF SHALL be 0.
REQ-008 Branch target SHALL be PCPlus4F + (sign-extended InstructionIn[15:0] << 2), 32-bit modulo arithmetic, overflow discarded.
REQ-009 Jump target SHALL be {PCPlus4F[31:28], InstructionIn[25:0], 2'b00}.
REQ-010 Next PC priority, highest first: Mispredict -> CorrectPC; Fetch_Enable=0 -> hold PCF; predictF=1 -> branch/jump target; else PCPlus4F.
REQ-011 Mispredict SHALL redirect PCF even when Fetch_Enable=0.
REQ-012 On ResolveValid=1 the indexed counter SHALL increment if ResolveTaken=1, decrement otherwise, saturating at 3 and 0; no other counter changes.
REQ-013 Counter updates SHALL occur regardless of Fetch_Enable and Mispredict.
REQ-014 Same-index lookup and update in one cycle: predictF SHALL use the pre-update value; new value visible next cycle.
REQ-015 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 Latency: redirect or prediction target SHALL appear on PCF exactly one cycle after the deciding edge; no bubbles inserted by this block.

Reset
REQ-017 While Reset=0, PCF SHALL be RESET_PC immediately (asynchronously) and all BHT counters SHALL be 2'b01 (weakly not-taken).
REQ-018 Reset asserted mid-stall or mid-redirect SHALL discard the pending Mispredict/update; first post-reset edge with Fetch_Enable=1 SHALL set PCF = RESET_PC + 4 when InstructionIn is sequential.

Verification
REQ-019 Reset release, InstructionIn=NOP, Fetch_Enable=1 for 3 edges -> PCF = 0, 4, 8, 12; predictF=0 throughout.
REQ-020 PCF=0x40, InstructionIn=beq imm=0x0003, counter=01 -> predictF=0, next PCF=0x44; after two ResolveValid/ResolveTaken=1 at ResolvePC=0x40 -> predictF=1, next PCF=0x50.
REQ-021 PCF=0x100, InstructionIn=j addr=0x0000040 -> predictF=1, next PCF=0x100.
REQ-022 Fetch_Enable=0 and Mispredict=1 with CorrectPC=0x200 same cycle -> next PCF=0x200; Mispredict=0 with Fetch_Enable=0 -> PCF holds.
REQ-023 Counter at 3, ResolveTaken=1 three times -> stays 3; then ResolveTaken=0 four times -> 2,1,0,0.
REQ-024 Reset pulsed low between clock edges while PCF=0x80 -> PCF=0x0 before next edge, all counters 01.

Source files
------------

// File: rtl/fetch_predict_unit.sv
// rtl/fetch_predict_unit.sv - fetch-stage PC register with predecode and 2-bit BHT prediction
//
// Purpose: holds the fetch PC, predecodes the fetched word, predicts
// conditional branches with a table of 2-bit saturating counters, predicts
// jumps always taken, and selects the next PC.
//
// Ports:
//   Clk           in   1  clock, rising edge
//   Reset         in   1  asynchronous reset, active low
//   Fetch_Enable  in   1  1 = advance PC, 0 = stall (hold PC)
//   InstructionIn in  32  instruction memory read data at PCF
//   ResolveValid  in   1  a conditional branch resolved this cycle
//   ResolvePC     in  32  address of the resolved branch
//   ResolveTaken  in   1  actual outcome of the resolved branch
//   Mispredict    in   1  redirect to CorrectPC this cycle
//   CorrectPC     in  32  redirect target
//   PCF           out 32  current fetch address
//   PCPlus4F      out 32  PCF + 4
//   InstructionF  out 32  InstructionIn passed through
//   predictF      out  1  fetched instruction predicted taken
module fetch_predict_unit #(
  parameter int unsigned BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Fetch_Enable,
  input  logic [31:0] InstructionIn,
  input  logic        ResolveValid,
  input  logic [31:0] ResolvePC,
  input  logic        ResolveTaken,
  input  logic        Mispredict,
  input  logic [31:0] CorrectPC,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstructionF,
  output logic        predictF
);

  localparam int unsigned BHT_ENTRIES = 1 << BHT_BITS;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [31:0]         pc_q, pc_d;
  logic [1:0]          bht_q [BHT_ENTRIES];
  logic [5:0]          opcode;
  logic                is_branch, is_jump;
  logic [BHT_BITS-1:0] fetch_idx, resolve_idx;
  logic [31:0]         branch_off, branch_target, jump_target, pred_target;

  assign PCF          = pc_q;
  assign PCPlus4F     = pc_q + 32'd4;  // wraps FFFF_FFFC -> 0 naturally
  assign InstructionF = InstructionIn;

  assign opcode      = InstructionIn[31:26];
  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_jump     = (opcode == OP_J);
  assign fetch_idx   = pc_q[BHT_BITS+1:2];
  assign resolve_idx = ResolvePC[BHT_BITS+1:2];

  // Lookup reads the registered counter, so a same-cycle update to the same
  // entry is only seen on the following cycle.
  assign predictF = is_jump | (is_branch & bht_q[fetch_idx][1]);

  assign branch_off    = {{14{InstructionIn[15]}}, InstructionIn[15:0], 2'b00};
  assign branch_target = PCPlus4F + branch_off;
  assign jump_target   = {PCPlus4F[31:28], InstructionIn[25:0], 2'b00};
  assign pred_target   = is_jump ? jump_target : branch_target;

  // Redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = PCPlus4F;
    if (Mispredict) begin
      pc_d = CorrectPC;
    end else if (!Fetch_Enable) begin
      pc_d = pc_q;
    end else if (predictF) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Training is independent of stall and redirect.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (ResolveValid) begin
      if (ResolveTaken) begin
        if (bht_q[resolve_idx] != 2'b11) begin
          bht_q[resolve_idx] <= bht_q[resolve_idx] + 2'd1;
        end
      end else begin
        if (bht_q[resolve_idx] != 2'b00) begin
          bht_q[resolve_idx] <= bht_q[resolve_idx] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// tb/tb_fetch_predict_unit.sv - self-checking bench for fetch_predict_unit
module tb_fetch_predict_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Fetch_Enable = 1'b0;
  logic [31:0] InstructionIn = 32'h0;
  logic        ResolveValid = 1'b0;
  logic [31:0] ResolvePC = 32'h0;
  logic        ResolveTaken = 1'b0;
  logic        Mispredict = 1'b0;
  logic [31:0] CorrectPC = 32'h0;
  logic [31:0] PCF, PCPlus4F, InstructionF;
  logic        predictF;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_bht [64];

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_predict_unit #(.BHT_BITS(6), .RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .Fetch_Enable(Fetch_Enable),
    .InstructionIn(InstructionIn), .ResolveValid(ResolveValid),
    .ResolvePC(ResolvePC), .ResolveTaken(ResolveTaken),
    .Mispredict(Mispredict), .CorrectPC(CorrectPC),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstructionF(InstructionF),
    .predictF(predictF)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mk_beq(input logic [15:0] imm);
    return {6'd4, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] mk_bne(input logic [15:0] imm);
    return {6'd5, 5'd3, 5'd4, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [25:0] addr);
    return {6'd2, addr};
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_predict(input logic [31:0] instr, input logic [31:0] pc);
    int op;
    op = int'(instr >> 26);
    if (op == 4 || op == 5) return m_bht[m_idx(pc)] >= 2;
    return op == 2;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] instr, input logic [31:0] pc);
    shortint imm;
    int      op;
    logic [31:0] seq;
    op  = int'(instr >> 26);
    seq = pc + 32'd4;
    if (op == 2) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    imm = shortint'(instr[15:0]);
    return seq + 32'(int'(imm) * 4);
  endfunction

  task automatic m_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  // Advance one rising edge, updating the model from pre-edge inputs.
  task automatic tick();
    logic [31:0] nxt;
    int          k;
    @(posedge Clk);
    if (!Reset) begin
      m_reset();
    end else begin
      if (Mispredict)                       nxt = CorrectPC;
      else if (!Fetch_Enable)               nxt = m_pc;
      else if (m_predict(InstructionIn, m_pc)) nxt = m_target(InstructionIn, m_pc);
      else                                  nxt = m_pc + 32'd4;
      if (ResolveValid) begin
        k = m_idx(ResolvePC);
        if (ResolveTaken && m_bht[k] < 3) m_bht[k]++;
        else if (!ResolveTaken && m_bht[k] > 0) m_bht[k]--;
      end
      m_pc = nxt;
    end
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] pc);
    Mispredict = 1'b1;
    CorrectPC  = pc;
    tick();
    Mispredict = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    InstructionIn = NOP;
    m_reset();
    #2;
    n_checks++;
    if (PCF !== 32'h0) begin n_fail++; $display("FAIL reset_pcf: got %h expected %h", PCF, 32'h0); end
    n_checks++;
    if (PCPlus4F !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus4: got %h expected %h", PCPlus4F, 32'h4); end
    n_checks++;
    if (predictF !== 1'b0) begin n_fail++; $display("FAIL reset_predict: got %b expected 0", predictF); end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_sequential();
    Fetch_Enable  = 1'b1;
    InstructionIn = NOP;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (PCF !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pcf[%0d]: got %h expected %h", i, PCF, 32'(4 * i)); end
      n_checks++;
      if (predictF !== 1'b0) begin n_fail++; $display("FAIL seq_predict[%0d]: got %b expected 0", i, predictF); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h40);
    Fetch_Enable  = 1'b1;
    InstructionIn = mk_beq(16'h0003);
    #1;
    n_checks++;
    if (predictF !== 1'b0) begin n_fail++; $display("FAIL beq_weak_predict: got %b expected 0", predictF); end
    tick();
    n_checks++;
    if (PCF !== 32'h44) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h expected %h", PCF, 32'h44); end
    goto_pc(32'h40);
    Fetch_Enable = 1'b0;
    ResolveValid = 1'b1;
    ResolvePC    = 32'h40;
    ResolveTaken = 1'b1;
    tick();
    tick();
    ResolveValid = 1'b0;
    Fetch_Enable = 1'b1;
    #1;
    n_checks++;
    if (predictF !== 1'b1) begin n_fail++; $display("FAIL beq_trained_predict: got %b expected 1", predictF); end
    tick();
    n_checks++;
    if (PCF !== 32'h50) begin n_fail++; $display("FAIL beq_taken_pc: got %h expected %h", PCF, 32'h50); end
    // Negative offset: bne at 0x50 with imm -2 goes to 0x54 - 8 = 0x4C once trained
    InstructionIn = mk_bne(16'hFFFE);
    Fetch_Enable  = 1'b0;
    ResolveValid  = 1'b1;
    ResolvePC     = 32'h50;
    ResolveTaken  = 1'b1;
    tick();
    ResolveValid  = 1'b0;
    Fetch_Enable  = 1'b1;
    tick();
    n_checks++;
    if (PCF !== 32'h4C) begin n_fail++; $display("FAIL bne_negative_pc: got %h expected %h", PCF, 32'h4C); end
  endtask

  task automatic test_jump();
    goto_pc(32'h100);
    Fetch_Enable  = 1'b1;
    InstructionIn = mk_j(26'h0000040);
    #1;
    n_checks++;
    if (predictF !== 1'b1) begin n_fail++; $display("FAIL jump_predict: got %b expected 1", predictF); end
    tick();
    n_checks++;
    if (PCF !== 32'h100) begin n_fail++; $display("FAIL jump_target: got %h expected %h", PCF, 32'h100); end
  endtask

  task automatic test_stall_redirect();
    Fetch_Enable  = 1'b0;
    InstructionIn = mk_j(26'h0000123);
    Mispredict    = 1'b1;
    CorrectPC     = 32'h200;
    tick();
    Mispredict    = 1'b0;
    #1;
    n_checks++;
    if (PCF !== 32'h200) begin n_fail++; $display("FAIL stall_redirect_pc: got %h expected %h", PCF, 32'h200); end
    tick();
    tick();
    n_checks++;
    if (PCF !== 32'h200) begin n_fail++; $display("FAIL stall_hold_pc: got %h expected %h", PCF, 32'h200); end
    // Redirect wins over a predicted jump
    Fetch_Enable = 1'b1;
    Mispredict   = 1'b1;
    CorrectPC    = 32'h340;
    tick();
    Mispredict   = 1'b0;
    n_checks++;
    if (PCF !== 32'h340) begin n_fail++; $display("FAIL redirect_over_jump: got %h expected %h", PCF, 32'h340); end
  endtask

  task automatic test_saturation();
    int pre [4] = '{3, 2, 1, 0};
    goto_pc(32'h40);
    Fetch_Enable  = 1'b0;
    InstructionIn = mk_beq(16'h0003);
    ResolvePC     = 32'h40;
    ResolveValid  = 1'b1;
    ResolveTaken  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (predictF !== 1'b1) begin n_fail++; $display("FAIL sat_high[%0d]: got %b expected 1", i, predictF); end
    end
    ResolveTaken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (predictF !== (pre[i] >= 2)) begin n_fail++; $display("FAIL sat_dec_preupdate[%0d]: got %b expected %b", i, predictF, pre[i] >= 2); end
      tick();
    end
    ResolveValid = 1'b0;
    #1;
    n_checks++;
    if (predictF !== 1'b0) begin n_fail++; $display("FAIL sat_low: got %b expected 0", predictF); end
    ResolveValid = 1'b1;
    ResolveTaken = 1'b1;
    tick();
    n_checks++;
    if (predictF !== 1'b0) begin n_fail++; $display("FAIL sat_low_recover1: got %b expected 0", predictF); end
    tick();
    ResolveValid = 1'b0;
    n_checks++;
    if (predictF !== 1'b1) begin n_fail++; $display("FAIL sat_low_recover2: got %b expected 1", predictF); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    Fetch_Enable  = 1'b1;
    InstructionIn = NOP;
    #1;
    n_checks++;
    if (PCPlus4F !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus4: got %h expected %h", PCPlus4F, 32'h0); end
    tick();
    n_checks++;
    if (PCF !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", PCF, 32'h0); end
  endtask

  task automatic test_async_reset();
    goto_pc(32'h80);
    Fetch_Enable  = 1'b1;
    InstructionIn = NOP;
    Mispredict    = 1'b1;
    CorrectPC     = 32'h300;
    ResolveValid  = 1'b1;
    ResolvePC     = 32'h40;
    ResolveTaken  = 1'b1;
    #3;
    Reset = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (PCF !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h expected %h", PCF, 32'h0); end
    @(negedge Clk);
    Reset        = 1'b1;
    Mispredict   = 1'b0;
    ResolveValid = 1'b0;
    tick();
    n_checks++;
    if (PCF !== 32'h4) begin n_fail++; $display("FAIL post_reset_first_pc: got %h expected %h", PCF, 32'h4); end
    // Index 0x40 was trained to 2 before reset; it must now be weakly not-taken.
    goto_pc(32'h40);
    Fetch_Enable  = 1'b0;
    InstructionIn = mk_beq(16'h0003);
    #1;
    n_checks++;
    if (predictF !== 1'b0) begin n_fail++; $display("FAIL reset_bht_predict: got %b expected 0", predictF); end
    ResolveValid = 1'b1;
    ResolvePC    = 32'h40;
    ResolveTaken = 1'b1;
    tick();
    ResolveValid = 1'b0;
    n_checks++;
    if (predictF !== 1'b1) begin n_fail++; $display("FAIL reset_bht_weak: got %b expected 1", predictF); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 500; c++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      InstructionIn = mk_beq(16'($urandom_range(0, 31)) - 16'd16);
      else if (r < 5) InstructionIn = mk_bne(16'($urandom_range(0, 31)) - 16'd16);
      else if (r < 6) InstructionIn = mk_j(26'($urandom_range(0, 255)));
      else            InstructionIn = {6'($urandom_range(6, 63)), 26'($urandom)};
      Fetch_Enable = ($urandom_range(0, 4) != 0);
      Mispredict   = ($urandom_range(0, 9) == 0);
      CorrectPC    = 32'($urandom_range(0, 127)) << 2;
      ResolveValid = ($urandom_range(0, 1) == 1);
      ResolvePC    = 32'($urandom_range(0, 127)) << 2;
      ResolveTaken = ($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (PCF !== m_pc) begin n_fail++; $display("FAIL rnd_pcf[%0d]: got %h expected %h", c, PCF, m_pc); end
      n_checks++;
      if (PCPlus4F !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pcplus4[%0d]: got %h expected %h", c, PCPlus4F, m_pc + 32'd4); end
      n_checks++;
      if (InstructionF !== InstructionIn) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h expected %h", c, InstructionF, InstructionIn); end
      n_checks++;
      if (predictF !== m_predict(InstructionIn, m_pc)) begin n_fail++; $display("FAIL rnd_predict[%0d]: got %b expected %b", c, predictF, m_predict(InstructionIn, m_pc)); end
      tick();
    end
    Mispredict   = 1'b0;
    ResolveValid = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_redirect();
    test_saturation();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
